rv32i_mem_arbiter: RTL and testbench



---
 rtl/rv32i_mem_arbiter.sv | 161 ++++++++++++++++
 tb/tb_rv32i_mem_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rv32i_mem_arbiter
// Brief    : Round-robin arbiter that shares one single-port synchronous RAM
//            between the instruction-fetch port and the load/store port.
// Revision : 1.0 - initial release
// ============================================================================
module rv32i_mem_arbiter #(
    parameter int MEM_LATENCY = 1,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_ireq,
    input  logic [ADDR_WIDTH-1:0] i_iaddr,
    output logic                  o_iack,
    output logic [31:0]           o_irdata,
    input  logic                  i_dreq,
    input  logic                  i_dwe,
    input  logic [ADDR_WIDTH-1:0] i_daddr,
    input  logic [31:0]           i_dwdata,
    input  logic [3:0]            i_dmask,
    output logic                  o_dack,
    output logic [31:0]           o_drdata,
    output logic                  o_mem_en,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [3:0]            o_mem_wmask,
    output logic [31:0]           o_mem_wdata,
    input  logic [31:0]           i_mem_rdata,
    output logic                  o_busy
);

    localparam int CNT_W = 3;
    localparam logic [CNT_W-1:0] C_CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_ACK   = 2'd3
    } state_t;

    state_t                r_state_q,       w_state_d;
    logic [CNT_W-1:0]      r_cnt_q,         w_cnt_d;
    logic                  r_ptr_data_q,    w_ptr_data_d;
    logic                  r_owner_data_q,  w_owner_data_d;
    logic                  r_mem_en_q,      w_mem_en_d;
    logic [ADDR_WIDTH-1:0] r_mem_addr_q,    w_mem_addr_d;
    logic [3:0]            r_mem_wmask_q,   w_mem_wmask_d;
    logic [31:0]           r_mem_wdata_q,   w_mem_wdata_d;
    logic [31:0]           r_irdata_q,      w_irdata_d;
    logic [31:0]           r_drdata_q,      w_drdata_d;
    logic                  r_iack_q,        w_iack_d;
    logic                  r_dack_q,        w_dack_d;
    logic                  r_busy_q,        w_busy_d;
    logic                  w_grant_data;

    // Data wins when it is the only requester or when the pointer favours it.
    assign w_grant_data = i_dreq && (!i_ireq || r_ptr_data_q);

    always_comb begin
        w_state_d      = r_state_q;
        w_cnt_d        = r_cnt_q;
        w_ptr_data_d   = r_ptr_data_q;
        w_owner_data_d = r_owner_data_q;
        w_mem_en_d     = 1'b0;
        w_mem_addr_d   = r_mem_addr_q;
        w_mem_wmask_d  = r_mem_wmask_q;
        w_mem_wdata_d  = r_mem_wdata_q;
        w_irdata_d     = r_irdata_q;
        w_drdata_d     = r_drdata_q;
        w_iack_d       = 1'b0;
        w_dack_d       = 1'b0;
        w_busy_d       = r_busy_q;

        case (r_state_q)
            S_IDLE: begin
                if (i_ireq || i_dreq) begin
                    w_owner_data_d = w_grant_data;
                    w_ptr_data_d   = !w_grant_data;
                    w_mem_en_d     = 1'b1;
                    w_mem_addr_d   = w_grant_data ? i_daddr : i_iaddr;
                    w_mem_wmask_d  = (w_grant_data && i_dwe) ? i_dmask : 4'b0000;
                    w_mem_wdata_d  = w_grant_data ? i_dwdata : 32'h0;
                    w_busy_d       = 1'b1;
                    w_state_d      = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cnt_d   = C_CNT_LOAD;
                w_state_d = S_WAIT;
            end
            S_WAIT: begin
                if (r_cnt_q == '0) begin
                    if (r_owner_data_q) begin
                        w_drdata_d = i_mem_rdata;
                        w_dack_d   = 1'b1;
                    end else begin
                        w_irdata_d = i_mem_rdata;
                        w_iack_d   = 1'b1;
                    end
                    w_state_d = S_ACK;
                end else begin
                    w_cnt_d = r_cnt_q - 1'b1;
                end
            end
            S_ACK: begin
                // Requests are deliberately ignored here so a held req is not granted twice.
                w_busy_d  = 1'b0;
                w_state_d = S_IDLE;
            end
            default: begin
                w_state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state_q      <= S_IDLE;
            r_cnt_q        <= '0;
            r_ptr_data_q   <= 1'b1;
            r_owner_data_q <= 1'b0;
            r_mem_en_q     <= 1'b0;
            r_mem_addr_q   <= '0;
            r_mem_wmask_q  <= 4'b0000;
            r_mem_wdata_q  <= 32'h0;
            r_irdata_q     <= 32'h0;
            r_drdata_q     <= 32'h0;
            r_iack_q       <= 1'b0;
            r_dack_q       <= 1'b0;
            r_busy_q       <= 1'b0;
        end else begin
            r_state_q      <= w_state_d;
            r_cnt_q        <= w_cnt_d;
            r_ptr_data_q   <= w_ptr_data_d;
            r_owner_data_q <= w_owner_data_d;
            r_mem_en_q     <= w_mem_en_d;
            r_mem_addr_q   <= w_mem_addr_d;
            r_mem_wmask_q  <= w_mem_wmask_d;
            r_mem_wdata_q  <= w_mem_wdata_d;
            r_irdata_q     <= w_irdata_d;
            r_drdata_q     <= w_drdata_d;
            r_iack_q       <= w_iack_d;
            r_dack_q       <= w_dack_d;
            r_busy_q       <= w_busy_d;
        end
    end

    assign o_iack      = r_iack_q;
    assign o_irdata    = r_irdata_q;
    assign o_dack      = r_dack_q;
    assign o_drdata    = r_drdata_q;
    assign o_mem_en    = r_mem_en_q;
    assign o_mem_addr  = r_mem_addr_q;
    assign o_mem_wmask = r_mem_wmask_q;
    assign o_mem_wdata = r_mem_wdata_q;
    assign o_busy      = r_busy_q;

endmodule
`default_nettype wire

// File: tb/tb_rv32i_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rv32i_mem_arbiter
// Brief    : Scoreboard bench for rv32i_mem_arbiter at MEM_LATENCY 1, 2 and 4.
// Revision : 1.0 - initial release
// ============================================================================
module tb_rv32i_mem_arbiter;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic [3:0]  wmask;
        logic [31:0] wdata;
    } mexp_t;

    typedef struct {
        int          cyc;
        logic        is_d;
        logic [31:0] irdata;
        logic        chk_d;
        logic [31:0] drdata;
    } aexp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_tot = 0;
    int          n_pass = 0;

    logic        rst      [3];
    logic        ireq     [3];
    logic [31:0] iaddr    [3];
    logic        dreq     [3];
    logic        dwe      [3];
    logic [31:0] daddr    [3];
    logic [31:0] dwdata   [3];
    logic [3:0]  dmask    [3];
    logic        iack     [3];
    logic [31:0] irdata   [3];
    logic        dack     [3];
    logic [31:0] drdata   [3];
    logic        mem_en   [3];
    logic [31:0] mem_addr [3];
    logic [3:0]  mem_wmask[3];
    logic [31:0] mem_wdata[3];
    logic [31:0] mem_rdata[3];
    logic        busy     [3];
    logic        prev_en  [3];

    mexp_t mem_q [3][$];
    aexp_t ack_q [3][$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0040: return 32'h1234_5678;
            default:       return 32'hC0DE_0000 | {16'h0, a[15:0]};
        endcase
    endfunction

    generate
        for (genvar g = 0; g < 3; g++) begin : g_dut
            localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 2 : 4);
            logic [31:0] pipe [4];

            // Synchronous RAM model: data valid exactly LAT cycles after o_mem_en.
            always @(posedge clk) begin
                pipe[0] <= mem_en[g] ? mem_read(mem_addr[g]) : 32'hDEAD_BEEF;
                for (int k = 1; k < 4; k++) pipe[k] <= pipe[k-1];
            end
            assign mem_rdata[g] = pipe[LAT-1];

            rv32i_mem_arbiter #(.MEM_LATENCY(LAT), .ADDR_WIDTH(32)) u_dut (
                .i_clk      (clk),
                .i_rst      (rst[g]),
                .i_ireq     (ireq[g]),
                .i_iaddr    (iaddr[g]),
                .o_iack     (iack[g]),
                .o_irdata   (irdata[g]),
                .i_dreq     (dreq[g]),
                .i_dwe      (dwe[g]),
                .i_daddr    (daddr[g]),
                .i_dwdata   (dwdata[g]),
                .i_dmask    (dmask[g]),
                .o_dack     (dack[g]),
                .o_drdata   (drdata[g]),
                .o_mem_en   (mem_en[g]),
                .o_mem_addr (mem_addr[g]),
                .o_mem_wmask(mem_wmask[g]),
                .o_mem_wdata(mem_wdata[g]),
                .i_mem_rdata(mem_rdata[g]),
                .o_busy     (busy[g])
            );
        end
    endgenerate

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    endtask

    task automatic fail(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        $display("FAIL %s: actual=0x%08h expected=0x%08h", name, act, exp);
    endtask

    // Monitor: pops the scoreboard whenever a DUT presents an access or an ack.
    always @(negedge clk) begin
        mexp_t m;
        aexp_t a;
        for (int d = 0; d < 3; d++) begin
            if (mem_en[d] === 1'b1) begin
                if (prev_en[d] === 1'b1)
                    fail($sformatf("d%0d_mem_en_back_to_back", d), 32'd1, 32'd0);
                if (mem_q[d].size() == 0) begin
                    fail($sformatf("d%0d_unexpected_mem_access", d), mem_addr[d], 32'h0);
                end else begin
                    m = mem_q[d].pop_front();
                    chk($sformatf("d%0d_mem_cycle", d), 32'(cyc), 32'(m.cyc));
                    chk($sformatf("d%0d_mem_addr", d), mem_addr[d], m.addr);
                    chk($sformatf("d%0d_mem_wmask", d), {28'h0, mem_wmask[d]}, {28'h0, m.wmask});
                    chk($sformatf("d%0d_mem_wdata", d), mem_wdata[d], m.wdata);
                end
            end
            prev_en[d] <= mem_en[d];
            if (iack[d] === 1'b1 || dack[d] === 1'b1) begin
                if (ack_q[d].size() == 0) begin
                    fail($sformatf("d%0d_unexpected_ack", d), {30'h0, iack[d], dack[d]}, 32'h0);
                end else begin
                    a = ack_q[d].pop_front();
                    chk($sformatf("d%0d_ack_cycle", d), 32'(cyc), 32'(a.cyc));
                    chk($sformatf("d%0d_ack_owner", d), {30'h0, iack[d], dack[d]},
                        a.is_d ? 32'd1 : 32'd2);
                    chk($sformatf("d%0d_irdata", d), irdata[d], a.irdata);
                    if (a.chk_d) chk($sformatf("d%0d_drdata", d), drdata[d], a.drdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_mem(input int d, input int c, input logic [31:0] ad,
                            input logic [3:0] wm, input logic [31:0] wd);
        mexp_t m;
        m.cyc = c; m.addr = ad; m.wmask = wm; m.wdata = wd;
        mem_q[d].push_back(m);
    endtask

    task automatic push_ack(input int d, input int c, input logic is_d,
                            input logic [31:0] ir, input logic chk_d, input logic [31:0] dr);
        aexp_t a;
        a.cyc = c; a.is_d = is_d; a.irdata = ir; a.chk_d = chk_d; a.drdata = dr;
        ack_q[d].push_back(a);
    endtask

    task automatic drain(input int d);
        int k = 0;
        while (ack_q[d].size() != 0 && k < 80) begin
            @(negedge clk);
            #1;
            k++;
        end
        if (ack_q[d].size() != 0) begin
            fail($sformatf("d%0d_ack_timeout", d), 32'(ack_q[d].size()), 32'h0);
            ack_q[d].delete();
        end
    endtask

    task automatic set_d(input int d, input logic req, input logic we,
                         input logic [31:0] ad, input logic [31:0] wd, input logic [3:0] mk);
        dreq[d] = req; dwe[d] = we; daddr[d] = ad; dwdata[d] = wd; dmask[d] = mk;
    endtask

    task automatic chk_all_zero(input int d, input string tag);
        chk($sformatf("d%0d_%s_ctrl", d, tag),
            {23'h0, busy[d], iack[d], dack[d], mem_en[d], 1'b0, mem_wmask[d]}, 32'h0);
        chk($sformatf("d%0d_%s_addr", d, tag), mem_addr[d], 32'h0);
        chk($sformatf("d%0d_%s_wdata", d, tag), mem_wdata[d], 32'h0);
        chk($sformatf("d%0d_%s_irdata", d, tag), irdata[d], 32'h0);
        chk($sformatf("d%0d_%s_drdata", d, tag), drdata[d], 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int c0;
        for (int d = 0; d < 3; d++) begin
            rst[d] = 1'b1; ireq[d] = 1'b0; iaddr[d] = 32'h0;
            set_d(d, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        end
        repeat (3) tick();
        chk_all_zero(0, "reset");
        for (int d = 0; d < 3; d++) rst[d] = 1'b0;
        tick();

        // Both requesters held high from reset: DATA, INST, DATA, INST.
        c0 = cyc;
        ireq[0] = 1'b1; iaddr[0] = 32'h200;
        set_d(0, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        push_mem(0, c0 + 1,  32'h300, 4'h0, 32'h0);
        push_mem(0, c0 + 5,  32'h200, 4'h0, 32'h0);
        push_mem(0, c0 + 9,  32'h300, 4'h0, 32'h0);
        push_mem(0, c0 + 13, 32'h200, 4'h0, 32'h0);
        push_ack(0, c0 + 3,  1'b1, 32'h0,         1'b1, 32'hC0DE_0300);
        push_ack(0, c0 + 7,  1'b0, 32'hC0DE_0200, 1'b1, 32'hC0DE_0300);
        push_ack(0, c0 + 11, 1'b1, 32'hC0DE_0200, 1'b1, 32'hC0DE_0300);
        push_ack(0, c0 + 15, 1'b0, 32'hC0DE_0200, 1'b1, 32'hC0DE_0300);
        drain(0);
        tick();
        ireq[0] = 1'b0;
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (2) tick();

        // Single fetch.
        c0 = cyc;
        ireq[0] = 1'b1; iaddr[0] = 32'h100;
        push_mem(0, c0 + 1, 32'h100, 4'h0, 32'h0);
        push_ack(0, c0 + 3, 1'b0, 32'h0050_0093, 1'b1, 32'hC0DE_0300);
        tick();
        chk("d0_busy_rise", {31'h0, busy[0]}, 32'd1);
        drain(0);
        tick();
        ireq[0] = 1'b0;
        chk("d0_busy_fall", {31'h0, busy[0]}, 32'd0);
        tick();

        // Store; instruction rdata must be untouched.
        c0 = cyc;
        set_d(0, 1'b1, 1'b1, 32'h2004, 32'hAABB_CCDD, 4'b1100);
        push_mem(0, c0 + 1, 32'h2004, 4'b1100, 32'hAABB_CCDD);
        push_ack(0, c0 + 3, 1'b1, 32'h0050_0093, 1'b0, 32'h0);
        drain(0);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Load at latency 1.
        c0 = cyc;
        set_d(0, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        push_mem(0, c0 + 1, 32'h40, 4'h0, 32'h0);
        push_ack(0, c0 + 3, 1'b1, 32'h0050_0093, 1'b1, 32'h1234_5678);
        drain(0);
        tick();
        set_d(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();

        // Fetch request dropped (and address changed) mid-transaction.
        c0 = cyc;
        ireq[0] = 1'b1; iaddr[0] = 32'h180;
        push_mem(0, c0 + 1, 32'h180, 4'h0, 32'h0);
        push_ack(0, c0 + 3, 1'b0, 32'hC0DE_0180, 1'b1, 32'h1234_5678);
        repeat (2) tick();
        ireq[0] = 1'b0; iaddr[0] = 32'h999;
        drain(0);
        repeat (8) tick();

        // Latency 2: a complete load, then a load aborted by reset mid-WAIT.
        c0 = cyc;
        set_d(1, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        push_mem(1, c0 + 1, 32'h40, 4'h0, 32'h0);
        push_ack(1, c0 + 4, 1'b1, 32'h0, 1'b1, 32'h1234_5678);
        drain(1);
        tick();
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        c0 = cyc;
        set_d(1, 1'b1, 1'b0, 32'h300, 32'h0, 4'h0);
        push_mem(1, c0 + 1, 32'h300, 4'h0, 32'h0);
        repeat (2) tick();
        rst[1] = 1'b1;
        set_d(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        tick();
        chk_all_zero(1, "midwait_reset");
        rst[1] = 1'b0;
        repeat (10) tick();

        // Latency 4 load.
        c0 = cyc;
        set_d(2, 1'b1, 1'b0, 32'h40, 32'h0, 4'h0);
        push_mem(2, c0 + 1, 32'h40, 4'h0, 32'h0);
        push_ack(2, c0 + 6, 1'b1, 32'h0, 1'b1, 32'h1234_5678);
        drain(2);
        tick();
        set_d(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
        repeat (6) tick();

        for (int d = 0; d < 3; d++) begin
            chk($sformatf("d%0d_mem_q_empty", d), 32'(mem_q[d].size()), 32'h0);
            chk($sformatf("d%0d_ack_q_empty", d), 32'(ack_q[d].size()), 32'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
